// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count, almost/sticky-error flags.
// Define FIFO_SYNC_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module fifo_sync_param #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int AFULL_TH   = 28,
  parameter int AEMPTY_TH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write,
  input  logic [WIDTH-1:0]      datain,
  input  logic                  read,
  output logic [WIDTH-1:0]      dataout,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_ovf, r_unf;
  logic                  w_rd_acc, w_wr_acc;
  assign count        = r_count;
  assign full         = r_count == (ADDR_WIDTH+1)'(DEPTH);
  assign empty        = r_count == '0;
  assign almost_full  = r_count >= (ADDR_WIDTH+1)'(AFULL_TH);
  assign almost_empty = r_count <= (ADDR_WIDTH+1)'(AEMPTY_TH);
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
  // A pop frees a slot in the same edge, so a write while full is still taken when a read is.
  assign w_rd_acc = read & ~empty;
  assign w_wr_acc = write & (~full | w_rd_acc);
  always_ff @(posedge clock)
    if (w_wr_acc) r_mem[r_wptr] <= datain;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_wptr  <= w_wr_acc ? r_wptr + 1'b1 : r_wptr;
      r_rptr  <= w_rd_acc ? r_rptr + 1'b1 : r_rptr;
      r_count <= (w_wr_acc & ~w_rd_acc) ? r_count + 1'b1 :
                 (w_rd_acc & ~w_wr_acc) ? r_count - 1'b1 : r_count;
      r_ovf   <= r_ovf | (write & ~w_wr_acc);
      r_unf   <= r_unf | (read & empty);
    end
`ifdef FIFO_SYNC_FWFT_EN
  assign dataout = empty ? '0 : r_mem[r_rptr];
`else
  logic [WIDTH-1:0] r_dout;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_dout <= '0;
    else if (w_rd_acc) r_dout <= r_mem[r_rptr];
  assign dataout = r_dout;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed self-checking bench for fifo_sync_param, both read modes.
module tb_fifo_sync_param;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       write = 1'b0, read = 1'b0;
  logic [7:0] datain = '0;
  logic [7:0] dataout;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [5:0] count;
  int         checks = 0, errors = 0;
  int         wv, rv;
  fifo_sync_param dut (
    .clock(clk), .reset(rst), .write(write), .datain(datain), .read(read),
    .dataout(dataout), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    write = 1'b0;
    read  = 1'b0;
    rst   = 1'b1;
    step;
    rst   = 1'b0;
  endtask
  // Pops one word with read held as set by caller; checks the word seen in the current read mode.
  task automatic pop_check(input string tag, input int exp);
`ifdef FIFO_SYNC_FWFT_EN
    chk(tag, dataout, exp[7:0]);
    step;
`else
    step;
    chk(tag, dataout, exp[7:0]);
`endif
  endtask
  initial begin
    // reset with a busy bench
    write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      datain = 8'(i + 8'h40);
      step;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    chk("rst_dout", dataout, 0);
    do_reset;
    // fill
    write = 1'b1;
    for (int i = 0; i < 32; i++) begin
      datain = 8'(i);
      step;
      chk("fill_count", count, i + 1);
      chk("fill_afull", almost_full, (i + 1) >= 28);
      chk("fill_aempty", almost_empty, (i + 1) <= 4);
    end
    chk("fill_full", full, 1);
    chk("fill_noovf", overflow, 0);
    datain = 8'hEE;
    step;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 32);
    write = 1'b0;
    // drain
    read = 1'b1;
    for (int i = 0; i < 32; i++) begin
      pop_check("drain_data", i);
      chk("drain_count", count, 31 - i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_noufl", underflow, 0);
    step;
    chk("unf_set", underflow, 1);
    chk("unf_count", count, 0);
`ifdef FIFO_SYNC_FWFT_EN
    chk("unf_dout", dataout, 0);
`else
    chk("unf_dout_hold", dataout, 8'h1F);
`endif
    read = 1'b0;
    // simultaneous read/write at count 16 across wrap
    do_reset;
    write = 1'b1;
    for (wv = 0; wv < 16; wv++) begin
      datain = 8'(wv);
      step;
    end
    chk("mid_count", count, 16);
    rv = 0;
    read = 1'b1;
    for (int i = 0; i < 40; i++) begin
      datain = 8'(wv);
      wv++;
      pop_check("rw16_data", rv);
      rv++;
      chk("rw16_count", count, 16);
    end
    read = 1'b0;
    for (int i = 0; i < 16; i++) begin
      datain = 8'(wv);
      wv++;
      step;
    end
    chk("rw32_full", full, 1);
    read = 1'b1;
    for (int i = 0; i < 40; i++) begin
      datain = 8'(wv);
      wv++;
      pop_check("rw32_data", rv);
      rv++;
      chk("rw32_full", full, 1);
    end
    chk("rw32_count", count, 32);
    chk("rw32_noovf", overflow, 0);
    chk("rw32_nounf", underflow, 0);
    // read+write from empty
    do_reset;
    write = 1'b1;
    read  = 1'b1;
    datain = 8'h77;
    step;
    write = 1'b0;
    read  = 1'b0;
    chk("rwe_count", count, 1);
    chk("rwe_unf", underflow, 1);
`ifdef FIFO_SYNC_FWFT_EN
    chk("rwe_dout", dataout, 8'h77);
    do_reset;
    chk("fwft_empty_dout", dataout, 0);
    write = 1'b1;
    datain = 8'hA5;
    step;
    write = 1'b0;
    chk("fwft_dout", dataout, 8'hA5);
    chk("fwft_count", count, 1);
`else
    chk("rwe_dout", dataout, 0);
`endif
    // reset mid-burst
    do_reset;
    write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      datain = 8'(8'h90 + i);
      step;
    end
    rst = 1'b1;
    #1;
    chk("mrst_count", count, 0);
    chk("mrst_empty", empty, 1);
    write = 1'b0;
    step;
    rst = 1'b0;
    write = 1'b1;
    datain = 8'h3C;
    step;
    write = 1'b0;
    read = 1'b1;
    pop_check("mrst_data", 8'h3C);
    read = 1'b0;
    chk("mrst_end_empty", empty, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
